// File: rtl/msp_tx_arbiter.sv
// Packet-atomic arbiter merging MSP responses (s0) and telemetry (s1) onto one UART byte stream,
// with round-robin tie breaking and abort/drain of a granted source that stops supplying bytes.
module msp_tx_arbiter #(
   parameter int unsigned STALL_CYCLES = 72_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] s0_data,
   input  logic       s0_valid,
   input  logic       s0_last,
   output logic       s0_ready,
   input  logic [7:0] s1_data,
   input  logic       s1_valid,
   input  logic       s1_last,
   output logic       s1_ready,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [1:0] grant,
   output logic       busy,
   output logic       abort,
   output logic [7:0] abort_count
);
   localparam int unsigned CNT_W = 24;
   localparam int unsigned ACNT_W = 8;
   localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, GRANT0, GRANT1, DRAIN0, DRAIN1} state_e;

   state_e              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
   logic [ACNT_W-1:0]   abort_cnt_q, abort_cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         stall_cnt_q  <= '0;
         abort_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         stall_cnt_q  <= stall_cnt_d;
         abort_cnt_q  <= abort_cnt_d;
      end
   end

   // Next state, stall counter and the zero-latency datapath mux.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      stall_cnt_d  = stall_cnt_q;
      abort_cnt_d  = abort_cnt_q;
      tx_data      = '0;
      tx_valid     = 1'b0;
      s0_ready     = 1'b0;
      s1_ready     = 1'b0;
      grant        = 2'b00;
      abort        = 1'b0;
      busy         = (state_q != IDLE);

      unique case (state_q)
         IDLE: begin
            if (s0_valid && s1_valid) state_d = last_grant_q ? GRANT0 : GRANT1;
            else if (s0_valid)        state_d = GRANT0;
            else if (s1_valid)        state_d = GRANT1;
         end
         GRANT0: begin
            grant    = 2'b01;
            tx_data  = s0_data;
            tx_valid = s0_valid;
            s0_ready = tx_ready;
            if (s0_valid && tx_ready) begin
               stall_cnt_d = '0;
               if (s0_last) begin
                  state_d      = IDLE;
                  last_grant_d = 1'b0;
               end
            end else if (!s0_valid) begin
               if (stall_cnt_q == STALL_LIM) begin
                  state_d = DRAIN0;
                  abort   = 1'b1;
               end else begin
                  stall_cnt_d = stall_cnt_q + 1'b1;
               end
            end
         end
         GRANT1: begin
            grant    = 2'b10;
            tx_data  = s1_data;
            tx_valid = s1_valid;
            s1_ready = tx_ready;
            if (s1_valid && tx_ready) begin
               stall_cnt_d = '0;
               if (s1_last) begin
                  state_d      = IDLE;
                  last_grant_d = 1'b1;
               end
            end else if (!s1_valid) begin
               if (stall_cnt_q == STALL_LIM) begin
                  state_d = DRAIN1;
                  abort   = 1'b1;
               end else begin
                  stall_cnt_d = stall_cnt_q + 1'b1;
               end
            end
         end
         // Drain swallows the rest of an aborted packet; a second stall just gives up.
         DRAIN0: begin
            s0_ready = 1'b1;
            if (s0_valid) begin
               stall_cnt_d = '0;
               if (s0_last) state_d = IDLE;
            end else if (stall_cnt_q == STALL_LIM) begin
               state_d = IDLE;
            end else begin
               stall_cnt_d = stall_cnt_q + 1'b1;
            end
         end
         DRAIN1: begin
            s1_ready = 1'b1;
            if (s1_valid) begin
               stall_cnt_d = '0;
               if (s1_last) state_d = IDLE;
            end else if (stall_cnt_q == STALL_LIM) begin
               state_d = IDLE;
            end else begin
               stall_cnt_d = stall_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q) stall_cnt_d = '0;
      if (abort && (abort_cnt_q != {ACNT_W{1'b1}})) abort_cnt_d = abort_cnt_q + 1'b1;
   end

   assign abort_count = abort_cnt_q;

endmodule

// File: doc/msp_tx_arbiter.md
MSP_TX_ARBITER -- requirements
Module: msp_tx_arbiter

Interface
REQ-001 Parameter STALL_CYCLES, default 72_000: consecutive source-starved cycles that abort a granted packet (1 ms at 72 MHz); legal range 2..2^24-1.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 s0_data  input  8  source 0 (MSP response) byte.
REQ-005 s0_valid  input  1  source 0 byte valid.
REQ-006 s0_last  input  1  source 0 byte is final byte of packet.
REQ-007 s0_ready  output  1  source 0 byte accepted.
REQ-008 s1_data, s1_valid, s1_last  input  8/1/1  source 1 (telemetry) byte, valid, last.
REQ-009 s1_ready  output  1  source 1 byte accepted.
REQ-010 tx_data  output  8  byte to PC UART.
REQ-011 tx_valid  output  1  tx_data valid.
REQ-012 tx_ready  input  1  UART accepts byte.
REQ-013 grant  output  2  one-hot owner (bit0 = s0, bit1 = s1); 00 = none.
REQ-014 busy  output  1  state is not IDLE.
REQ-015 abort  output  1  one-cycle pulse when a packet is aborted on stall.
REQ-016 abort_count  output  8  saturating count of aborts.

Function
REQ-017 States: IDLE, GRANT0, GRANT1, DRAIN0, DRAIN1.
REQ-018 Handshake: a byte transfers on a cycle where valid and ready are both high; data is held stable by the producer while valid and not ready.
REQ-019 GRANTn: tx_data = sn_data, tx_valid = sn_valid, sn_ready = tx_ready; all are combinational, with zero added latency; the other source's ready = 0.
REQ-020 IDLE: tx_valid = 0, s0_ready = s1_ready = 0; this gives packet-atomic output and no byte interleaving.
REQ-021 IDLE arbitration: only s0_valid -> GRANT0; only s1_valid -> GRANT1; both -> the source not served last (round-robin register last_grant; reset value = 1, so s0 wins the first tie); the grant takes effect the next cycle.
REQ-022 GRANTn -> IDLE the cycle after a handshake with sn_last = 1; last_grant updates to n at that time. At least one IDLE cycle separates consecutive packets.
REQ-023 Stall counter: 24-bit; increments in GRANTn on cycles with sn_valid = 0; clears on any handshake and on any state change.
REQ-024 tx_ready = 0 with sn_valid = 1 is downstream backpressure: the counter holds and does not increment; there is no abort.
REQ-025 When the counter reaches STALL_CYCLES in GRANTn, the next state is DRAINn; abort pulses high that same cycle; abort_count increments, saturating at 255.
REQ-026 DRAINn: sn_ready = 1, tx_valid = 0, bytes are discarded, and the counter runs as in REQ-023.
REQ-027 DRAINn -> IDLE on a handshake with sn_last = 1, or on the counter reaching STALL_CYCLES again; no second abort pulse is issued.
REQ-028 grant = 01 in GRANT0, 10 in GRANT1, 00 otherwise, including DRAIN.
REQ-029 A last byte stalled by tx_ready = 0 holds the grant until the handshake.
REQ-030 A single-byte packet (valid and last on the first byte) releases after one handshake.

Reset
REQ-031 While rst_n = 0 and on release:
- state IDLE
- grant = 00, busy = 0, tx_valid = 0, s0_ready = s1_ready = 0
- abort = 0, abort_count = 0
- counter = 0, last_grant = 1
REQ-032 Reset asserted mid-packet drops the packet immediately and asynchronously; no drain follows after release.

Verification
REQ-033 s0 sends a 6-byte packet (24 4D 3E ..), tx_ready = 1 -> grant = 01 one cycle after s0_valid; tx_data matches byte-for-byte over 6 consecutive cycles; grant = 00 on the cycle after the last byte.
REQ-034 s0 and s1 raise valid on the same cycle, 3 packets each -> output order s0, s1, s0, s1, s0, s1; no interleaved bytes; one IDLE cycle between packets.
REQ-035 s1 granted, tx_ready toggling 1/0 every cycle for 10,000 cycles -> no abort; all bytes delivered in order.
REQ-036 With STALL_CYCLES = 16, s0 sends 2 bytes then drops valid for 16 cycles -> abort pulses once, abort_count = 1, grant = 00. The 3 remaining s0 bytes, including last, are accepted and not forwarded. A subsequent s1 packet is then delivered intact.
REQ-037 rst_n pulled low mid-packet during GRANT1 -> all outputs take reset values the same cycle; after release, s0_valid alone yields grant = 01.
REQ-038 Force 300 stall aborts -> abort_count saturates at 255.
